// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide controller for the E stage of the pipelined MIPS
// core. It owns HI/LO, sequences a fixed-latency busy period for
// mult/multu/div/divu, writes HI/LO directly for mthi/mtlo, and raises a
// combinational D-stage stall for MD-class instructions.
// Optional feature: define MDU_STALL_CNT_EN to get a free-running count of
// stalled cycles on stall_cnt; when undefined stall_cnt is tied to 0.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        req,
   input  logic        d_is_md,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        stall_req,
   output logic [31:0] stall_cnt
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [3:0]         r_cnt;
   logic [31:0]        r_tmp_hi;
   logic [31:0]        r_tmp_lo;
   logic               r_dz;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;

   logic               w_accept;
   logic               w_commit;
   logic               w_md_op;
   logic signed [63:0] w_prod_s;
   logic [63:0]        w_prod_u;
   logic [31:0]        w_b_safe;
   logic signed [31:0] w_quo_s;
   logic signed [31:0] w_rem_s;
   logic [31:0]        w_quo_u;
   logic [31:0]        w_rem_u;

   // Ops that occupy the unit for a busy period (and therefore stall D)
   assign w_md_op = (op == OP_MULT) || (op == OP_MULTU) ||
                    (op == OP_DIV)  || (op == OP_DIVU);

   // Arithmetic results; a zero divisor is replaced by 1 so the temps never
   // go unknown -- the commit is suppressed for that case anyway.
   assign w_prod_s = $signed(a) * $signed(b);
   assign w_prod_u = {32'd0, a} * {32'd0, b};
   assign w_b_safe = (b == 32'd0) ? 32'd1 : b;
   assign w_quo_s  = $signed(a) / $signed(w_b_safe);
   assign w_rem_s  = $signed(a) % $signed(w_b_safe);
   assign w_quo_u  = a / w_b_safe;
   assign w_rem_u  = a % w_b_safe;

   assign busy      = (r_state == S_BUSY);
   assign hi        = r_hi;
   assign lo        = r_lo;
   assign stall_req = d_is_md && (busy || (start && w_md_op && !req));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic: accept only in IDLE without a flush, finish on count 1
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !req) begin
               w_accept = 1'b1;
               if (w_md_op) w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_cnt == 4'd1) begin
               w_commit    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: latch temps on accept, count down while busy, commit HI/LO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt    <= 4'd0;
         r_tmp_hi <= 32'd0;
         r_tmp_lo <= 32'd0;
         r_dz     <= 1'b0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
      end else if (w_accept) begin
         case (op)
            OP_MULT: begin
               {r_tmp_hi, r_tmp_lo} <= w_prod_s;
               r_cnt                <= 4'(MULT_CYCLES);
               r_dz                 <= 1'b0;
            end
            OP_MULTU: begin
               {r_tmp_hi, r_tmp_lo} <= w_prod_u;
               r_cnt                <= 4'(MULT_CYCLES);
               r_dz                 <= 1'b0;
            end
            OP_DIV: begin
               r_tmp_lo <= w_quo_s;
               r_tmp_hi <= w_rem_s;
               r_cnt    <= 4'(DIV_CYCLES);
               r_dz     <= (b == 32'd0);
            end
            OP_DIVU: begin
               r_tmp_lo <= w_quo_u;
               r_tmp_hi <= w_rem_u;
               r_cnt    <= 4'(DIV_CYCLES);
               r_dz     <= (b == 32'd0);
            end
            OP_MTHI: r_hi <= a;
            OP_MTLO: r_lo <= a;
            default: ;
         endcase
      end else if (r_state == S_BUSY) begin
         r_cnt <= r_cnt - 4'd1;
         if (w_commit && !r_dz) begin
            r_hi <= r_tmp_hi;
            r_lo <= r_tmp_lo;
         end
      end
   end

`ifdef MDU_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   // Count every edge on which the D stage is held
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          r_stall_cnt <= 32'd0;
      else if (stall_req) r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed test of mdu_ctrl. A transaction-level model tracks
// HI/LO, remaining busy cycles and the stall count; a negedge process compares
// the DUT against it every cycle, and literal expectations pin the model.
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        req = 1'b0;
   logic        d_is_md = 1'b0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        stall_req;
   logic [31:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .req(req), .d_is_md(d_is_md), .busy(busy), .hi(hi), .lo(lo),
      .stall_req(stall_req), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_left = 0;
   logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
   bit          m_pwr = 0;
   logic [31:0] m_scnt = 0;

   function automatic bit exp_stall();
      return d_is_md && ((m_left > 0) ||
             (start && op >= 3'd1 && op <= 3'd4 && !req));
   endfunction

   always @(posedge clk or posedge reset) begin
      longint          sa, sb, sp;
      longint unsigned up;
      if (reset) begin
         m_left = 0; m_hi = 0; m_lo = 0; m_pwr = 0; m_scnt = 0;
      end else begin
         if (exp_stall()) m_scnt = m_scnt + 1;
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
         end else if (start && !req) begin
            case (op)
               3'd1: begin sp = sa * sb; {m_phi, m_plo} = sp; m_pwr = 1; m_left = 5; end
               3'd2: begin up = longint'(a) * longint'(b); {m_phi, m_plo} = up; m_pwr = 1; m_left = 5; end
               3'd3: begin
                  m_pwr = (b != 0); m_left = 10;
                  if (b != 0) begin m_plo = 32'(sa / sb); m_phi = 32'(sa % sb); end
               end
               3'd4: begin
                  m_pwr = (b != 0); m_left = 10;
                  if (b != 0) begin m_plo = a / b; m_phi = a % b; end
               end
               3'd5: m_hi = a;
               3'd6: m_lo = a;
               default: ;
            endcase
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("cyc_busy", {63'd0, busy}, {63'd0, m_left > 0});
      chk("cyc_hi", {32'd0, hi}, {32'd0, m_hi});
      chk("cyc_lo", {32'd0, lo}, {32'd0, m_lo});
      chk("cyc_stall", {63'd0, stall_req}, {63'd0, exp_stall()});
`ifdef MDU_STALL_CNT_EN
      chk("cyc_scnt", {32'd0, stall_cnt}, {32'd0, m_scnt});
`else
      chk("cyc_scnt", {32'd0, stall_cnt}, 64'd0);
`endif
   end

   // Issue one op; count busy cycles after acceptance and stalled cycles
   task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic rq, input logic dmd, input bit midreq,
                         output int nbusy, output int nstall);
      int n;
      @(posedge clk); #1;
      start = 1'b1; op = o; a = va; b = vb; req = rq; d_is_md = dmd;
      #1 nstall = stall_req ? 1 : 0;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0; req = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         if (stall_req) nstall++;
         n++;
         if (midreq && n == 2) req = 1'b1;
         @(posedge clk); #1;
      end
      req = 1'b0; d_is_md = 1'b0;
      chk("busy_timeout", {63'd0, n >= 40}, 64'd0);
      nbusy = n;
   endtask

   initial begin
      int nb, ns;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_lo", {32'd0, lo}, 64'd0);
      chk("rst_scnt", {32'd0, stall_cnt}, 64'd0);

      // signed mult with D-stage MD instruction waiting
      run_op(3'd1, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b1, 0, nb, ns);
      chk("smul_nbusy", nb, 5);
      chk("smul_nstall", ns, 6);
      chk("smul_hi", {32'd0, hi}, 64'hFFFFFFFF);
      chk("smul_lo", {32'd0, lo}, 64'hFFFFFFEB);
`ifdef MDU_STALL_CNT_EN
      chk("smul_scnt", {32'd0, stall_cnt}, 64'd6);
`endif

      run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 0, nb, ns);
      chk("umul_nbusy", nb, 5);
      chk("umul_nstall", ns, 0);
      chk("umul_hi", {32'd0, hi}, 64'd1);
      chk("umul_lo", {32'd0, lo}, 64'hFFFFFFFE);

      run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 0, nb, ns);
      chk("sdiv_nbusy", nb, 10);
      chk("sdiv_lo", {32'd0, lo}, 64'hFFFFFFFD);
      chk("sdiv_hi", {32'd0, hi}, 64'hFFFFFFFF);

      run_op(3'd4, 32'd7, 32'd2, 1'b0, 1'b0, 0, nb, ns);
      chk("udiv_lo", {32'd0, lo}, 64'd3);
      chk("udiv_hi", {32'd0, hi}, 64'd1);

      run_op(3'd5, 32'd5, 32'd0, 1'b0, 1'b0, 0, nb, ns);
      chk("mthi5_nbusy", nb, 0);
      run_op(3'd6, 32'd6, 32'd0, 1'b0, 1'b0, 0, nb, ns);
      chk("pre_hi", {32'd0, hi}, 64'd5);
      chk("pre_lo", {32'd0, lo}, 64'd6);

      run_op(3'd3, 32'd100, 32'd0, 1'b0, 1'b0, 0, nb, ns);
      chk("dz_nbusy", nb, 10);
      chk("dz_hi", {32'd0, hi}, 64'd5);
      chk("dz_lo", {32'd0, lo}, 64'd6);

      run_op(3'd1, 32'd3, 32'd3, 1'b1, 1'b1, 0, nb, ns);
      chk("reqst_nbusy", nb, 0);
      chk("reqst_nstall", ns, 0);
      chk("reqst_hi", {32'd0, hi}, 64'd5);
      chk("reqst_lo", {32'd0, lo}, 64'd6);

      run_op(3'd5, 32'h12345678, 32'd0, 1'b0, 1'b0, 0, nb, ns);
      chk("mthi_nbusy", nb, 0);
      chk("mthi_hi", {32'd0, hi}, 64'h12345678);

      run_op(3'd6, 32'hDEADBEEF, 32'd0, 1'b1, 1'b0, 0, nb, ns);
      chk("mtlo_req_lo", {32'd0, lo}, 64'd6);

      run_op(3'd1, 32'hFFFFFFFD, 32'd4, 1'b0, 1'b0, 1, nb, ns);
      chk("midreq_nbusy", nb, 5);
      chk("midreq_hi", {32'd0, hi}, 64'hFFFFFFFF);
      chk("midreq_lo", {32'd0, lo}, 64'hFFFFFFF4);

      // reset in the third busy cycle of a div
      @(posedge clk); #1;
      start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_busy", {63'd0, busy}, 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_hi", {32'd0, hi}, 64'd0);
      chk("mid_rst_lo", {32'd0, lo}, 64'd0);
      chk("mid_rst_scnt", {32'd0, stall_cnt}, 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("post_rst_busy", {63'd0, busy}, 64'd0);
      chk("post_rst_lo", {32'd0, lo}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the pipelined MIPS CPU, sitting in the E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from E and sequences a fixed-latency busy period.
- Owns the HI/LO registers that feed the W-stage register-data select (mfhi/mflo path).
- Generates the D-stage stall request for MD-class instructions and honours exception/interrupt cancellation from CP0.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  E-stage instruction is a valid MD op this cycle
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- a  input  32  rs operand (forwarded)
- b  input  32  rt operand (forwarded)
- req  input  1  CP0 exception/interrupt flush this cycle
- d_is_md  input  1  D-stage instruction is MD-class (mult/div/mthi/mtlo/mfhi/mflo)
- busy  output  1  operation in progress
- hi  output  32  HI register
- lo  output  32  LO register
- stall_req  output  1  stall D stage
- stall_cnt  output  32  stall cycle counter (optional feature)

Behaviour:
- Reset (async, immediate): hi=0, lo=0, busy=0, internal counter=0, result temps=0, state IDLE, stall_cnt=0.
- Accept condition: start && !req && state==IDLE. Any other start is ignored. Start while BUSY cannot occur legally because stall_req blocks it; if it does occur, it is dropped.
- mult/multu:
  - At the accepting edge, latch the 64-bit product {tmp_hi,tmp_lo}: signed for mult, unsigned for multu.
  - Load counter=MULT_CYCLES and go to BUSY.
- div/divu:
  - Latch tmp_lo=quotient and tmp_hi=remainder. Signed division truncates toward zero and the remainder takes the dividend's sign.
  - Load counter=DIV_CYCLES and go to BUSY.
  - b==0: the op still runs the full busy period, but hi/lo are left unchanged at completion.
- mthi/mtlo: write a to hi/lo at the accepting edge. busy stays 0 and the state stays IDLE.
- BUSY:
  - busy=1; the counter decrements each cycle.
  - In the cycle where counter==1, the edge commits hi/lo from the temps (subject to the divide-by-zero rule), clears busy and returns to IDLE.
  - Timing: start sampled at edge T0 gives busy=1 for exactly N cycles after T0. New hi/lo are visible in the first cycle with busy=0.
- req rules:
  - req suppresses acceptance, including mthi/mtlo writes.
  - req does not abort an op already in BUSY; the older instruction completes.
- stall_req = d_is_md && (busy || (start && op is mult/multu/div/divu && !req)). This is combinational.
- hi/lo change only at completion or on an mthi/mtlo edge; they are stable while busy=1.
- reset mid-operation: returns to IDLE at once, no commit, hi/lo=0.
- Back-to-back: an op accepted in the first IDLE cycle after completion uses the freshly committed hi/lo. There is no bubble in the controller itself.

Optional Feature:
- Macro: MDU_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 (wrapping at 2^32) on every clock edge where stall_req==1. Reset clears it to 0.
- Undefined: stall_cnt is constant 0 and no counter register is inferred.

Test Plan:
- Signed mult: start, op=1, a=32'hFFFFFFFD, b=7 -> busy high for 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- Unsigned mult: op=2, a=32'hFFFFFFFF, b=2 -> after 5 busy cycles, hi=1, lo=32'hFFFFFFFE.
- div/divu:
  - op=3, a=-7, b=2 -> busy for 10 cycles, then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
  - op=4, a=7, b=2 -> lo=3, hi=1.
  - op=3, b=0 with hi/lo preloaded to 5/6 -> 10 busy cycles, hi/lo stay 5/6.
- Stall and req interplay:
  - d_is_md=1 during a mult -> stall_req=1 in the start cycle plus 5 busy cycles, then 0.
  - start with req=1 (op=1) -> busy stays 0, hi/lo unchanged.
  - req asserted mid-BUSY -> op still completes.
- mthi/mtlo:
  - mthi a=32'h12345678 -> hi updates next edge, busy stays 0.
  - mtlo with req=1 -> lo unchanged.
- Reset during BUSY (cycle 3 of a div) -> busy=0, hi=lo=0 immediately.
  - With MDU_STALL_CNT_EN defined, stall_cnt=0 immediately; after a 6-cycle mult stall, stall_cnt=6.
